camo_key_loader: RTL and testbench

//  Sequential key loader feeding camouflaged-gate select inputs D_0..D_(2*NUM_GATES-1) of the obfuscated c432 netlist.

---
 rtl/camo_key_loader_if.sv | 29 ++
 rtl/camo_key_loader.sv | 118 +++++++++++
 tb/tb_camo_key_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/camo_key_loader_if.sv
// Key-loader bus: serial key handshake in, committed key, tie rails and status out.
// master = key source, slave = loader.
interface camo_key_loader_if #(
    parameter int NUM_GATES = 5
);
    localparam int KW = 2 * NUM_GATES;

    logic          LOAD_START;
    logic          KEY_VALID;
    logic          KEY_BIT;
    logic          KEY_READY;
    logic [KW-1:0] D;
    logic          CONST1;
    logic          CONST0;
    logic          KEY_OK;
    logic          KEY_ERR;
    logic          LOCKED;
    logic          BUSY;

    modport master (
        output LOAD_START, KEY_VALID, KEY_BIT,
        input  KEY_READY, D, CONST1, CONST0, KEY_OK, KEY_ERR, LOCKED, BUSY
    );

    modport slave (
        input  LOAD_START, KEY_VALID, KEY_BIT,
        output KEY_READY, D, CONST1, CONST0, KEY_OK, KEY_ERR, LOCKED, BUSY
    );
endinterface

// File: rtl/camo_key_loader.sv
// Serial key loader for camouflaged-gate selects: shifts in a key frame plus
// even-parity bit, checks it, then commits the key atomically to D.
module camo_key_loader #(
    parameter int                     NUM_GATES = 5,
    parameter logic [2*NUM_GATES-1:0] RESET_KEY = '1,
    parameter int                     LOCK_ONCE = 1
) (
    input logic                CLK,
    input logic                RST,
    camo_key_loader_if.slave   kif
);
    localparam int KW = 2 * NUM_GATES;
    localparam int CW = $clog2(KW + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, COMMIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [KW-1:0] shadow, shadow_n;
    logic [KW-1:0] d_q, d_n;
    logic          accum, accum_n;
    logic          par_bad, par_bad_n;
    logic          ok_q, ok_n;
    logic          err_q, err_n;
    logic          locked, locked_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            shadow  <= '0;
            d_q     <= RESET_KEY;
            accum   <= 1'b0;
            par_bad <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            locked  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shadow  <= shadow_n;
            d_q     <= d_n;
            accum   <= accum_n;
            par_bad <= par_bad_n;
            ok_q    <= ok_n;
            err_q   <= err_n;
            locked  <= locked_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shadow_n  = shadow;
        d_n       = d_q;
        accum_n   = accum;
        par_bad_n = par_bad;
        ok_n      = 1'b0;
        err_n     = 1'b0;
        locked_n  = locked;

        case (state)
            IDLE: begin
                if (kif.LOAD_START) begin
                    if (locked) begin
                        err_n = 1'b1;
                    end else begin
                        state_n  = SHIFT;
                        cnt_n    = '0;
                        shadow_n = '0;
                        accum_n  = 1'b0;
                    end
                end
            end
            SHIFT: begin
                // A restart wins over any bit transferred in the same cycle.
                if (kif.LOAD_START) begin
                    cnt_n    = '0;
                    shadow_n = '0;
                    accum_n  = 1'b0;
                end else if (kif.KEY_VALID) begin
                    if (cnt == CW'(KW)) begin
                        par_bad_n = accum ^ kif.KEY_BIT;
                        state_n   = CHECK;
                    end else begin
                        shadow_n = shadow | (KW'(kif.KEY_BIT) << cnt);
                        accum_n  = accum ^ kif.KEY_BIT;
                        cnt_n    = cnt + CW'(1);
                    end
                end
            end
            CHECK: begin
                if (par_bad) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = COMMIT;
                end
            end
            COMMIT: begin
                d_n      = shadow;
                ok_n     = 1'b1;
                locked_n = (LOCK_ONCE != 0);
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign kif.KEY_READY = (state == SHIFT);
    assign kif.BUSY      = (state != IDLE);
    assign kif.D         = d_q;
    assign kif.KEY_OK    = ok_q;
    assign kif.KEY_ERR   = err_q;
    assign kif.LOCKED    = locked;
    assign kif.CONST1    = 1'b1;
    assign kif.CONST0    = 1'b0;
endmodule

// File: tb/tb_camo_key_loader.sv
// Directed bench for camo_key_loader: one lock-once and one reloadable
// instance driven by the same key stream, checked against hand-computed values.
module tb_camo_key_loader;
    localparam int NG = 5;
    localparam int KW = 2 * NG;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_start = 1'b0;
    logic key_valid  = 1'b0;
    logic key_bit    = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    camo_key_loader_if #(.NUM_GATES(NG)) if_lock ();
    camo_key_loader_if #(.NUM_GATES(NG)) if_free ();

    assign if_lock.LOAD_START = load_start;
    assign if_lock.KEY_VALID  = key_valid;
    assign if_lock.KEY_BIT    = key_bit;
    assign if_free.LOAD_START = load_start;
    assign if_free.KEY_VALID  = key_valid;
    assign if_free.KEY_BIT    = key_bit;

    camo_key_loader #(.NUM_GATES(NG), .RESET_KEY('1), .LOCK_ONCE(1)) dut_lock (
        .CLK (clk),
        .RST (rst),
        .kif (if_lock)
    );

    camo_key_loader #(.NUM_GATES(NG), .RESET_KEY('1), .LOCK_ONCE(0)) dut_free (
        .CLK (clk),
        .RST (rst),
        .kif (if_free)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        key_valid = 1'b0;
        repeat (gap) step();
        key_valid = 1'b1;
        key_bit   = b;
        step();
        key_valid = 1'b0;
    endtask

    // Returns just after the parity-bit transfer edge.
    task automatic send_frame(input logic [KW-1:0] key, input logic par, input int max_gap);
        for (int i = 0; i < KW; i++) send_bit(key[i], $urandom_range(max_gap, 0));
        send_bit(par, $urandom_range(max_gap, 0));
    endtask

    initial begin
        logic [KW-1:0] k155;
        k155 = 10'h155;

        repeat (3) step();
        check("rst_d_lock",   32'(if_lock.D), 32'h3FF);
        check("rst_d_free",   32'(if_free.D), 32'h3FF);
        check("rst_const1",   32'(if_lock.CONST1), 32'd1);
        check("rst_const0",   32'(if_lock.CONST0), 32'd0);
        check("rst_ready",    32'(if_lock.KEY_READY), 32'd0);
        check("rst_locked",   32'(if_lock.LOCKED), 32'd0);
        check("rst_busy",     32'(if_lock.BUSY), 32'd0);
        check("rst_ok_err",   32'({if_lock.KEY_OK, if_lock.KEY_ERR}), 32'd0);
        rst = 1'b0;
        step();

        // Bad parity: 10'h001 has odd weight, parity bit 0 -> total parity 1.
        start();
        check("bad_ready", 32'(if_lock.KEY_READY), 32'd1);
        check("bad_busy",  32'(if_lock.BUSY), 32'd1);
        send_frame(10'h001, 1'b0, 0);
        check("bad_ready_check", 32'(if_lock.KEY_READY), 32'd0);
        step();
        check("bad_err_lock", 32'(if_lock.KEY_ERR), 32'd1);
        check("bad_err_free", 32'(if_free.KEY_ERR), 32'd1);
        check("bad_no_ok",    32'(if_lock.KEY_OK), 32'd0);
        step();
        check("bad_err_drop", 32'(if_lock.KEY_ERR), 32'd0);
        check("bad_no_ok2",   32'(if_lock.KEY_OK), 32'd0);
        check("bad_d_kept",   32'(if_lock.D), 32'h3FF);
        check("bad_unlocked", 32'(if_lock.LOCKED), 32'd0);
        check("bad_idle",     32'(if_lock.BUSY), 32'd0);

        // Good frame 10'h000, parity 0: commit 2 cycles after the parity edge.
        start();
        send_frame(10'h000, 1'b0, 0);
        step();
        check("good_ok_early", 32'(if_lock.KEY_OK), 32'd0);
        check("good_d_early",  32'(if_lock.D), 32'h3FF);
        step();
        check("good_ok_lock",  32'(if_lock.KEY_OK), 32'd1);
        check("good_ok_free",  32'(if_free.KEY_OK), 32'd1);
        check("good_no_err",   32'(if_lock.KEY_ERR), 32'd0);
        check("good_d_lock",   32'(if_lock.D), 32'h000);
        check("good_d_free",   32'(if_free.D), 32'h000);
        check("good_locked",   32'(if_lock.LOCKED), 32'd1);
        check("good_free_unl", 32'(if_free.LOCKED), 32'd0);
        step();
        check("good_ok_pulse", 32'(if_lock.KEY_OK), 32'd0);

        // Locked instance rejects; reloadable one takes a restarted frame with gaps.
        start();
        check("lock_err",        32'(if_lock.KEY_ERR), 32'd1);
        check("lock_not_ready",  32'(if_lock.KEY_READY), 32'd0);
        check("free_ready",      32'(if_free.KEY_READY), 32'd1);
        check("free_no_err",     32'(if_free.KEY_ERR), 32'd0);
        step();
        check("lock_err_pulse",  32'(if_lock.KEY_ERR), 32'd0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 1);
        send_bit(1'b1, 0);
        send_bit(1'b1, 2);
        // Restart with a coincident transfer; that bit must be dropped.
        load_start = 1'b1;
        key_valid  = 1'b1;
        key_bit    = 1'b1;
        step();
        load_start = 1'b0;
        key_valid  = 1'b0;
        check("restart_ready", 32'(if_free.KEY_READY), 32'd1);
        send_frame(10'h2A5, 1'b1, 3);
        check("lock_still_idle", 32'(if_lock.KEY_READY), 32'd0);
        step();
        step();
        check("reload_ok",     32'(if_free.KEY_OK), 32'd1);
        check("reload_d",      32'(if_free.D), 32'h2A5);
        check("lock_d_kept",   32'(if_lock.D), 32'h000);
        check("lock_no_ok",    32'(if_lock.KEY_OK), 32'd0);

        // Reset after 6 bits of a valid frame, then a full frame.
        step();
        start();
        for (int i = 0; i < 6; i++) send_bit(k155[i], 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_d_lock", 32'(if_lock.D), 32'h3FF);
        check("mid_rst_d_free", 32'(if_free.D), 32'h3FF);
        check("mid_rst_busy",   32'(if_free.BUSY), 32'd0);
        check("mid_rst_ready",  32'(if_free.KEY_READY), 32'd0);
        check("mid_rst_unlock", 32'(if_lock.LOCKED), 32'd0);
        step();
        start();
        send_frame(10'h155, 1'b1, 1);
        step();
        step();
        check("post_rst_ok",     32'(if_lock.KEY_OK), 32'd1);
        check("post_rst_d_lock", 32'(if_lock.D), 32'h155);
        check("post_rst_d_free", 32'(if_free.D), 32'h155);
        check("post_rst_locked", 32'(if_lock.LOCKED), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
